maxpool_window_feeder: RTL
==========================

Name: maxpool_window_feeder

Overview:
- Streaming producer for the MaxPool2D datapath. Accepts a row-major int8 pixel stream for one feature-map channel and buffers FILTER_H rows.
- Emits each non-overlapping FILTER_H×FILTER_W window as a flattened int8 array, in the element order the max-pool reducer consumes.
- Sits between the activation/feature-map output stream and the max-pool unit. Backpressure runs through a valid/ready handshake.

Parameters:
- IMG_W, 28, input feature-map width in pixels (must be ≥ FILTER_W)
- IMG_H, 28, input feature-map height in pixels (must be ≥ FILTER_H)
- FILTER_H, 2, pooling window height; vertical stride equals FILTER_H
- FILTER_W, 2, pooling window width; horizontal stride equals FILTER_W

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data holds a valid pixel
- in_ready  out  1  block accepts a pixel this cycle
- in_data  in  int8_t  pixel value, row-major order
- win_valid  out  1  win_data holds a complete window
- win_ready  in  1  consumer accepts the window this cycle
- win_data  out  int8_t [FILTER_H*FILTER_W]  window elements; index r*FILTER_W+c, where r and c are the row and column within the window
- win_last  out  1  qualifies win_valid; marks the final window of the frame

Behaviour:
- Reset is fully asynchronous and clears:
  - row counter, column counter, win_valid, win_last;
  - win_data to all zeros.
  - in_ready is 1 after reset.
  - Line-buffer contents need not be cleared.
- A pixel transfer occurs when in_valid && in_ready. A window transfer occurs when win_valid && win_ready.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on every pixel transfer.
  - col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts with no idle cycle.
- Valid-region rule (VALID padding, floor):
  - OUT_W = IMG_W/FILTER_W and OUT_H = IMG_H/FILTER_H.
  - Pixels with col ≥ OUT_W*FILTER_W or row ≥ OUT_H*FILTER_H are accepted and discarded. They are never stored in a window.
- Storage:
  - Line buffer of FILTER_H-1 rows × OUT_W*FILTER_W int8, addressed by col.
  - Plus FILTER_W-1 partial-row registers for the current row.
  - Row slot = row % FILTER_H.
- Window completion: a pixel transfer with row%FILTER_H == FILTER_H-1 and col%FILTER_W == FILTER_W-1 (inside the valid region) completes a window.
  - On the next edge, win_data is loaded with the FILTER_H×FILTER_W elements and win_valid is set to 1.
  - Latency: completing pixel to win_valid is 1 cycle.
- win_last is set with win_valid when the completing pixel is at window row OUT_H-1, window column OUT_W-1.
- Output register holds a single window.
  - win_data and win_last stay stable while win_valid && !win_ready.
  - win_valid clears after a window transfer unless a new window loads on the same edge.
- Flow control: in_ready = !win_valid || win_ready.
  - A full output stalls input even for non-completing pixels; this simplification is intentional.
  - Simultaneous window transfer and completing pixel transfer: the new window replaces the old one and win_valid stays 1.
- in_ready has a combinational path from win_ready. No combinational path exists from in_valid to win_valid.
- Reset mid-frame discards any partial window and the pending output. The first pixel after reset is (0,0).
- Arithmetic: values pass through unmodified and are signed int8. No saturation or scaling.
- Elaboration fails (assertion) if IMG_W < FILTER_W or IMG_H < FILTER_H.

Test Plan:
- Basic 4×4, 2×2, win_ready=1, pixels 0..15 row-major, in_valid continuous.
  - Required: windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}.
  - Each window appears 1 cycle after pixel 5, 7, 13, 15 respectively; win_last only on the fourth.
- Backpressure on the 4×4 stream: hold win_ready=0 for 5 cycles after the first window.
  - Required: win_data stays {0,1,4,5} and in_ready=0 throughout.
  - No pixel is lost; the remaining windows match the basic case.
- Non-multiple dimensions: IMG_W=5, IMG_H=5, pixels 0..24.
  - Required: exactly 4 windows, {0,1,5,6}, {2,3,7,8}, {10,11,15,16}, {12,13,17,18}.
  - win_last is set on the fourth window. Column 4 and row 4 are dropped.
- Signed values: 4×4 stream with pixel 0 = -128 and pixel 5 = 127.
  - Required: the first window is {-128,1,4,127} and the bit patterns are preserved.
- Back-to-back frames: two 4×4 frames (0..15, then 100..115) with no gap.
  - Required: eight windows; the fifth is {100,101,104,105}, and win_last is set on windows 4 and 8.
- Reset mid-frame: assert reset after pixel 9, then send a fresh 0..15.
  - Required: win_valid=0 immediately on reset.
  - The outputs then match the basic case exactly, with no stale window.

Source files
------------

// File: rtl/maxpool_window_feeder.sv
// Buffers FILTER_H rows of a row-major int8 stream and emits each
// non-overlapping FILTER_H x FILTER_W pooling window as one flattened word.
module maxpool_window_feeder #(
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int FILTER_H = 2,
   parameter int FILTER_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [7:0] in_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic signed [7:0] win_data [FILTER_H*FILTER_W],
   output logic              win_last
);

   localparam int OUT_W   = IMG_W / FILTER_W;
   localparam int OUT_H   = IMG_H / FILTER_H;
   localparam int VALID_W = OUT_W * FILTER_W;
   localparam int WIN_N   = FILTER_H * FILTER_W;
   localparam int LB_ROWS = (FILTER_H > 1) ? FILTER_H - 1 : 1;
   localparam int PART_N  = (FILTER_W > 1) ? FILTER_W - 1 : 1;
   localparam int CW      = $clog2(IMG_W + 1);
   localparam int RW      = $clog2(IMG_H + 1);
   localparam int CPW     = $clog2(FILTER_W + 1);
   localparam int RPW     = $clog2(FILTER_H + 1);
   localparam int WCW     = $clog2(OUT_W + 1);
   localparam int WRW     = $clog2(OUT_H + 1);

   if (IMG_W < FILTER_W || IMG_H < FILTER_H) begin : g_bad_cfg
      $error("maxpool_window_feeder: image smaller than pooling window");
   end

   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [CPW-1:0] col_phase;
   logic [RPW-1:0] row_phase;
   logic [WCW-1:0] win_col;
   logic [WRW-1:0] win_row;

   logic signed [7:0] line_buf [LB_ROWS][VALID_W];
   logic signed [7:0] part_row [PART_N];
   logic signed [7:0] assembled [WIN_N];

   logic in_fire;
   logic win_fire;
   logic in_region;
   logic col_end;
   logic row_end;
   logic row_last_slot;
   logic col_last_slot;
   logic store_line;
   logic store_part;
   logic complete;
   logic final_win;

   // A full output register stalls the input even for pixels that would not
   // complete a window; this keeps the ready path to a single gate.
   assign in_ready  = !win_valid || win_ready;
   assign in_fire   = in_valid && in_ready;
   assign win_fire  = win_valid && win_ready;

   assign col_end       = (col == CW'(IMG_W - 1));
   assign row_end       = (row == RW'(IMG_H - 1));
   assign row_last_slot = (row_phase == RPW'(FILTER_H - 1));
   assign col_last_slot = (col_phase == CPW'(FILTER_W - 1));
   assign in_region     = (win_col < WCW'(OUT_W)) && (win_row < WRW'(OUT_H));

   assign store_line = in_fire && in_region && !row_last_slot;
   assign store_part = in_fire && in_region && row_last_slot && !col_last_slot;
   assign complete   = in_fire && in_region && row_last_slot && col_last_slot;
   assign final_win  = (win_row == WRW'(OUT_H - 1)) && (win_col == WCW'(OUT_W - 1));

   // Phase and window-index counters track col%FILTER_W, col/FILTER_W etc.
   // incrementally so no dividers are needed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col       <= '0;
         row       <= '0;
         col_phase <= '0;
         row_phase <= '0;
         win_col   <= '0;
         win_row   <= '0;
      end else if (in_fire) begin
         if (col_end) begin
            col       <= '0;
            col_phase <= '0;
            win_col   <= '0;
            if (row_end) begin
               row       <= '0;
               row_phase <= '0;
               win_row   <= '0;
            end else begin
               row <= row + RW'(1);
               if (row_last_slot) begin
                  row_phase <= '0;
                  win_row   <= win_row + WRW'(1);
               end else begin
                  row_phase <= row_phase + RPW'(1);
               end
            end
         end else begin
            col <= col + CW'(1);
            if (col_last_slot) begin
               col_phase <= '0;
               win_col   <= win_col + WCW'(1);
            end else begin
               col_phase <= col_phase + CPW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < FILTER_H - 1; r++) begin
         for (int c = 0; c < VALID_W; c++) begin
            if (store_line && row_phase == RPW'(r) && col == CW'(c)) begin
               line_buf[r][c] <= in_data;
            end
         end
      end
      for (int c = 0; c < FILTER_W - 1; c++) begin
         if (store_part && col_phase == CPW'(c)) begin
            part_row[c] <= in_data;
         end
      end
   end

   // The completing pixel itself is the last element and is taken straight
   // from the input so the window loads on the same edge it is accepted.
   always_comb begin
      for (int i = 0; i < WIN_N; i++) begin
         assembled[i] = '0;
      end
      for (int r = 0; r < FILTER_H - 1; r++) begin
         for (int c = 0; c < FILTER_W; c++) begin
            for (int w = 0; w < OUT_W; w++) begin
               if (win_col == WCW'(w)) begin
                  assembled[r*FILTER_W + c] = line_buf[r][w*FILTER_W + c];
               end
            end
         end
      end
      for (int c = 0; c < FILTER_W - 1; c++) begin
         assembled[(FILTER_H-1)*FILTER_W + c] = part_row[c];
      end
      assembled[WIN_N-1] = in_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         for (int i = 0; i < WIN_N; i++) begin
            win_data[i] <= '0;
         end
      end else if (complete) begin
         win_valid <= 1'b1;
         win_last  <= final_win;
         win_data  <= assembled;
      end else if (win_fire) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end
   end

   a_hold_stable: assert property (@(posedge clk) disable iff (reset)
      (win_valid && !win_ready) |=> (win_valid && $stable(win_last)));

endmodule
